// File: rtl/digi_ota_gm_integrator.sv
// Digital OTA core: per-channel differential gm stage with tail-current clipping,
// a mode-selectable saturating integrator and a first-order sigma-delta readout.
module digi_ota_gm_integrator #(
  parameter int CHANNELS   = 2,
  parameter int WIDTH      = 8,
  parameter int GMW        = 4,
  parameter int ACC_W      = 16,
  parameter int I_MAX      = 1023,
  parameter int LEAK_SHIFT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic                      clr,
  input  logic [1:0]                mode,
  input  logic [GMW-1:0]            gm,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] inp,
  input  logic [CHANNELS*WIDTH-1:0] inn,
  output logic [CHANNELS*ACC_W-1:0] acc_out,
  output logic                      out_valid,
  output logic [CHANNELS-1:0]       sat,
  output logic [CHANNELS-1:0]       sd_out
);

  localparam int DW = WIDTH + 1;
  localparam int PW = WIDTH + GMW + 2;
  localparam int SW = ACC_W + 2;

  localparam logic signed [PW-1:0]    IMAX_P  = PW'(I_MAX);
  localparam logic signed [ACC_W-1:0] IMAX_A  = ACC_W'(I_MAX);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

  function automatic logic is_clipped(input logic signed [PW-1:0] p);
    return (p > IMAX_P) || (p < -IMAX_P);
  endfunction

  function automatic logic signed [ACC_W-1:0] clip_current(input logic signed [PW-1:0] p);
    logic signed [ACC_W-1:0] r;
    if (p > IMAX_P) begin
      r = IMAX_A;
    end else if (p < -IMAX_P) begin
      r = -IMAX_A;
    end else begin
      r = ACC_W'(p);
    end
    return r;
  endfunction

  function automatic logic overflows(input logic signed [SW-1:0] s);
    return (s > SW'(ACC_MAX)) || (s < SW'(ACC_MIN));
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SW-1:0] s);
    logic signed [ACC_W-1:0] r;
    if (s > SW'(ACC_MAX)) begin
      r = ACC_MAX;
    end else if (s < SW'(ACC_MIN)) begin
      r = ACC_MIN;
    end else begin
      r = ACC_W'(s);
    end
    return r;
  endfunction

  logic                    v1_q, v1_d, v2_q, v2_d, out_valid_q, out_valid_d;
  logic signed [DW-1:0]    d_q   [CHANNELS];
  logic signed [DW-1:0]    d_d   [CHANNELS];
  logic signed [ACC_W-1:0] i_q   [CHANNELS];
  logic signed [ACC_W-1:0] i_d   [CHANNELS];
  logic signed [ACC_W-1:0] acc_q [CHANNELS];
  logic signed [ACC_W-1:0] acc_d [CHANNELS];
  logic [ACC_W-1:0]        e_q   [CHANNELS];
  logic [ACC_W-1:0]        e_d   [CHANNELS];
  logic [CHANNELS-1:0]     clip_q, clip_d, sat_q, sat_d, sd_q, sd_d;
  logic signed [PW-1:0]    prod_s;
  logic signed [SW-1:0]    sum_s;
  logic [ACC_W:0]          sd_sum_s;

  // Next-state logic for all pipeline stages, accumulators and modulators.
  always_comb begin
    v1_d        = v1_q;
    v2_d        = v2_q;
    out_valid_d = out_valid_q;
    clip_d      = clip_q;
    sat_d       = sat_q;
    sd_d        = sd_q;
    prod_s      = {PW{1'b0}};
    sum_s       = {SW{1'b0}};
    sd_sum_s    = {(ACC_W+1){1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      d_d[c]   = d_q[c];
      i_d[c]   = i_q[c];
      acc_d[c] = acc_q[c];
      e_d[c]   = e_q[c];
    end

    if (ena) begin
      v1_d = in_valid;
      v2_d = v1_q;
      for (int c = 0; c < CHANNELS; c++) begin
        d_d[c]    = $signed({1'b0, inp[c*WIDTH +: WIDTH]}) - $signed({1'b0, inn[c*WIDTH +: WIDTH]});
        prod_s    = PW'(d_q[c]) * PW'($signed({1'b0, gm}));
        i_d[c]    = clip_current(prod_s);
        clip_d[c] = is_clipped(prod_s);
        // Offset-binary input: flipping the sign bit adds 2^(ACC_W-1).
        sd_sum_s  = {1'b0, e_q[c]} + {1'b0, ~acc_q[c][ACC_W-1], acc_q[c][ACC_W-2:0]};
        sd_d[c]   = sd_sum_s[ACC_W];
        e_d[c]    = sd_sum_s[ACC_W-1:0];
      end
    end else begin
      v1_d = v1_q;
    end

    // Clear wins over a stage-3 sample arriving in the same cycle.
    if (clr) begin
      out_valid_d = 1'b0;
      sat_d       = {CHANNELS{1'b0}};
      for (int c = 0; c < CHANNELS; c++) begin
        acc_d[c] = ACC_ZERO;
      end
    end else if (ena) begin
      out_valid_d = v2_q;
      for (int c = 0; c < CHANNELS; c++) begin
        if (v2_q) begin
          case (mode)
            2'b00: sum_s = SW'(acc_q[c]) + SW'(i_q[c]);
            2'b01: sum_s = SW'(acc_q[c]) + SW'(i_q[c]) - SW'(acc_q[c] >>> LEAK_SHIFT);
            2'b10: begin
              if (i_q[c][ACC_W-1]) begin
                sum_s = SW'(ACC_MIN);
              end else if (i_q[c] != ACC_ZERO) begin
                sum_s = SW'(ACC_MAX);
              end else begin
                sum_s = SW'(acc_q[c]);
              end
            end
            2'b11:   sum_s = SW'(i_q[c]);
            default: sum_s = SW'(acc_q[c]);
          endcase
          acc_d[c] = sat_acc(sum_s);
          sat_d[c] = sat_q[c] | clip_q[c] | overflows(sum_s);
        end else begin
          acc_d[c] = acc_q[c];
        end
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      clip_q      <= {CHANNELS{1'b0}};
      sat_q       <= {CHANNELS{1'b0}};
      sd_q        <= {CHANNELS{1'b0}};
      for (int c = 0; c < CHANNELS; c++) begin
        d_q[c]   <= {DW{1'b0}};
        i_q[c]   <= ACC_ZERO;
        acc_q[c] <= ACC_ZERO;
        e_q[c]   <= {ACC_W{1'b0}};
      end
    end else begin
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      out_valid_q <= out_valid_d;
      clip_q      <= clip_d;
      sat_q       <= sat_d;
      sd_q        <= sd_d;
      for (int c = 0; c < CHANNELS; c++) begin
        d_q[c]   <= d_d[c];
        i_q[c]   <= i_d[c];
        acc_q[c] <= acc_d[c];
        e_q[c]   <= e_d[c];
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_acc_out
    assign acc_out[g*ACC_W +: ACC_W] = acc_q[g];
  end

  assign out_valid = out_valid_q;
  assign sat       = sat_q;
  assign sd_out    = sd_q;

endmodule

// File: tb/tb_digi_ota_gm_integrator.sv
// Bench for digi_ota_gm_integrator: directed scenarios plus randomized traffic,
// all outputs compared every cycle against an integer reference model.
module tb_digi_ota_gm_integrator;

  localparam int CH   = 2;
  localparam int W    = 8;
  localparam int GMW  = 4;
  localparam int AW   = 16;
  localparam int IMAX = 1023;
  localparam int LS   = 4;
  localparam int AMAX = (1 << (AW - 1)) - 1;
  localparam int AMIN = -(1 << (AW - 1));

  logic            clk = 1'b0;
  logic            rst, ena, clr, in_valid, out_valid;
  logic [1:0]      mode;
  logic [GMW-1:0]  gm;
  logic [CH*W-1:0] inp, inn;
  logic [CH*AW-1:0] acc_out;
  logic [CH-1:0]   sat, sd_out;

  always #5 clk = ~clk;

  digi_ota_gm_integrator #(
    .CHANNELS(CH), .WIDTH(W), .GMW(GMW), .ACC_W(AW), .I_MAX(IMAX), .LEAK_SHIFT(LS)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .clr(clr), .mode(mode), .gm(gm),
    .in_valid(in_valid), .inp(inp), .inn(inn), .acc_out(acc_out),
    .out_valid(out_valid), .sat(sat), .sd_out(sd_out)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state, plain integers.
  int m_acc [CH];
  int m_sat [CH];
  int m_sd  [CH];
  int m_e   [CH];
  int s1_d  [CH];
  int s2_i  [CH];
  int s2_clip [CH];
  int s1_v, s2_v, m_ov;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               tag, $signed(obs), obs, $signed(exp), exp, $time);
    end
  endtask

  function automatic logic [31:0] acc_of(input int c);
    logic signed [AW-1:0] a;
    a = acc_out[c*AW +: AW];
    return {{(32-AW){a[AW-1]}}, a};
  endfunction

  task automatic model_step();
    int u, t, s, p, ovf, ov_n;
    if (rst) begin
      s1_v = 0; s2_v = 0; m_ov = 0;
      for (int c = 0; c < CH; c++) begin
        m_acc[c] = 0; m_sat[c] = 0; m_sd[c] = 0; m_e[c] = 0;
        s1_d[c] = 0; s2_i[c] = 0; s2_clip[c] = 0;
      end
    end else begin
      if (ena) begin
        for (int c = 0; c < CH; c++) begin
          u = m_acc[c] + (1 << (AW - 1));
          t = m_e[c] + u;
          m_sd[c] = (t >= (1 << AW)) ? 1 : 0;
          m_e[c]  = t % (1 << AW);
        end
        ov_n = s2_v;
        if (s2_v != 0) begin
          for (int c = 0; c < CH; c++) begin
            case (mode)
              2'd0: s = m_acc[c] + s2_i[c];
              2'd1: s = m_acc[c] + s2_i[c] - (m_acc[c] >>> LS);
              2'd2: s = (s2_i[c] > 0) ? AMAX : ((s2_i[c] < 0) ? AMIN : m_acc[c]);
              default: s = s2_i[c];
            endcase
            ovf = 0;
            if (s > AMAX) begin s = AMAX; ovf = 1; end
            if (s < AMIN) begin s = AMIN; ovf = 1; end
            m_acc[c] = s;
            if (ovf != 0 || s2_clip[c] != 0) m_sat[c] = 1;
          end
        end
        s2_v = s1_v;
        for (int c = 0; c < CH; c++) begin
          p = s1_d[c] * int'(gm);
          s2_clip[c] = (p > IMAX || p < -IMAX) ? 1 : 0;
          s2_i[c] = (p > IMAX) ? IMAX : ((p < -IMAX) ? -IMAX : p);
          s1_d[c] = int'(inp[c*W +: W]) - int'(inn[c*W +: W]);
        end
        s1_v = in_valid ? 1 : 0;
        m_ov = ov_n;
      end
      if (clr) begin
        m_ov = 0;
        for (int c = 0; c < CH; c++) begin
          m_acc[c] = 0; m_sat[c] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check_eq("out_valid", out_valid, m_ov);
    for (int c = 0; c < CH; c++) begin
      check_eq("acc_out", acc_of(c), m_acc[c]);
      check_eq("sat", sat[c], m_sat[c]);
      check_eq("sd_out", sd_out[c], m_sd[c]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic set_all(input int p, input int n);
    for (int c = 0; c < CH; c++) begin
      inp[c*W +: W] = p[W-1:0];
      inn[c*W +: W] = n[W-1:0];
    end
  endtask

  initial begin
    int a, mx, ones;
    rst = 1'b1; ena = 1'b0; clr = 1'b0; mode = 2'd0; gm = 4'd0;
    in_valid = 1'b0; inp = '0; inn = '0;

    // 1: reset, then idle with ena=1
    tick();
    check_eq("t1_rst_acc", acc_of(0), 32'd0);
    rst = 1'b0; ena = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq("t1_sd_alt", sd_out[0], k % 2);
    end

    // 2: plain integration up and back down
    mode = 2'd0; gm = 4'd3; set_all(100, 90); in_valid = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      check_eq("t2_latency", out_valid, (j >= 2) ? 1 : 0);
      if (j >= 2) check_eq("t2_step", acc_of(0), 30 * (j - 1));
    end
    in_valid = 1'b0;
    repeat (3) tick();
    check_eq("t2_final", acc_of(0), 32'd300);
    set_all(90, 100); in_valid = 1'b1;
    repeat (10) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check_eq("t2_back", acc_of(0), 32'd0);

    // 3: current clip and accumulator saturation, then clear
    gm = 4'd15; set_all(255, 0); in_valid = 1'b1;
    repeat (33) tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check_eq("t3_acc_max", acc_of(0), 32'd32767);
    check_eq("t3_sat", sat[0], 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("t3_clr_acc", acc_of(0), 32'd0);
    check_eq("t3_clr_sat", sat[0], 0);

    // 4: leaky integrator settles in its fixed-point band
    mode = 2'd1; gm = 4'd1; set_all(16, 0); in_valid = 1'b1;
    mx = -100000;
    repeat (150) begin
      tick();
      a = acc_of(0);
      if (a > mx) mx = a;
    end
    a = acc_of(0);
    check_eq("t4_settle", (a >= 256 && a <= 271) ? 1 : 0, 1);
    check_eq("t4_no_overshoot", (mx <= 271) ? 1 : 0, 1);

    // 5: comparator to negative rail, then follower at zero
    mode = 2'd2; gm = 4'd5; set_all(10, 50);
    repeat (6) tick();
    check_eq("t5_min", acc_of(0), 32'hFFFF_8000);
    ones = 0;
    repeat (16) begin
      tick();
      ones += int'(sd_out[0]);
    end
    check_eq("t5_density", ones, 0);
    mode = 2'd3; set_all(77, 77);
    repeat (4) tick();
    check_eq("t5_follow", acc_of(0), 32'd0);

    // 6: freeze mid-stream, then reset mid-stream
    clr = 1'b1; tick(); clr = 1'b0;
    mode = 2'd0; gm = 4'd2; in_valid = 1'b1;
    repeat (4) begin inp = 16'($urandom); inn = 16'($urandom); tick(); end
    ena = 1'b0;
    repeat (5) begin
      inp = 16'($urandom); inn = 16'($urandom); in_valid = 1'($urandom);
      tick();
    end
    ena = 1'b1; in_valid = 1'b0;
    repeat (6) tick();
    in_valid = 1'b1;
    repeat (3) begin inp = 16'($urandom); inn = 16'($urandom); tick(); end
    rst = 1'b1;
    tick();
    check_eq("t6_rst_acc", acc_of(0), 32'd0);
    check_eq("t6_rst_ov", out_valid, 0);
    rst = 1'b0; in_valid = 1'b0;
    repeat (4) begin
      tick();
      check_eq("t6_no_pending", out_valid, 0);
    end

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      ena      = ($urandom_range(0, 9) != 0);
      clr      = ena && ($urandom_range(0, 39) == 0);
      rst      = ($urandom_range(0, 199) == 0);
      mode     = 2'($urandom);
      gm       = GMW'($urandom);
      in_valid = 1'($urandom);
      inp      = 16'($urandom);
      inn      = 16'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
